// File: rtl/vflag_wr_sched_pkg.sv
// Shared constants, state encoding and lane helpers for the vector flag
// register file write-port scheduler.
package vflag_pkg;

    localparam int NUMLANES  = 2;
    localparam int WIDTH     = 4;
    localparam int LOGREGS   = 9;
    localparam int DEPTH     = 2 ** LOGREGS;

    localparam int DATA_W_ALL = NUMLANES * WIDTH;
    localparam int REG_W_ALL  = NUMLANES * LOGREGS;
    localparam int CNT_W      = LOGREGS + 1;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_e;

    // Every lane writes the same flag register address.
    function automatic logic [REG_W_ALL-1:0] rep_reg(input logic [LOGREGS-1:0] r);
        return {NUMLANES{r}};
    endfunction

endpackage

// File: rtl/vflag_wr_sched_if.sv
// Handshake and write-port bundle between flag producers, the scheduler
// and the flag register file.
interface vflag_wr_sched_if;
    import vflag_pkg::*;

    logic                  clr_start;
    logic                  clr_busy;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [LOGREGS-1:0]    req0_reg;
    logic [DATA_W_ALL-1:0] req0_data;
    logic [NUMLANES-1:0]   req0_mask;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [LOGREGS-1:0]    req1_reg;
    logic [DATA_W_ALL-1:0] req1_data;
    logic [NUMLANES-1:0]   req1_mask;

    logic [REG_W_ALL-1:0]  c_reg;
    logic [DATA_W_ALL-1:0] c_writedatain;
    logic [NUMLANES-1:0]   c_we;

    modport master (
        output clr_start,
        output req0_valid, req0_reg, req0_data, req0_mask,
        output req1_valid, req1_reg, req1_data, req1_mask,
        input  clr_busy, req0_ready, req1_ready,
        input  c_reg, c_writedatain, c_we
    );

    modport slave (
        input  clr_start,
        input  req0_valid, req0_reg, req0_data, req0_mask,
        input  req1_valid, req1_reg, req1_data, req1_mask,
        output clr_busy, req0_ready, req1_ready,
        output c_reg, c_writedatain, c_we
    );

endinterface

// File: rtl/vflag_wr_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves only when a grant
// is issued, so idle cycles never disturb fairness.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // After granting req0 favour req1 next, and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (|gnt) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/vflag_wr_sched.sv
// Flag register file write-port controller: bulk clear after reset or on
// command, otherwise round-robin between the compare and flag-logic units.
module vflag_wr_sched
    import vflag_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    vflag_wr_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            gnt;
    logic                  arb_en;
    logic                  clr_done;

    logic [REG_W_ALL-1:0]  c_reg_p0, c_reg_p1;
    logic [DATA_W_ALL-1:0] c_data_p0, c_data_p1;
    logic [NUMLANES-1:0]   vld_p0, vld_p1;

    assign clr_done = (cnt_q == CNT_LAST);
    // A clear request pre-empts any grant in the cycle it arrives.
    assign arb_en   = (state_q == ARB) && !bus.clr_start;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (resetn),
        .req ({bus.req1_valid, bus.req0_valid}),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.clr_busy   = (state_q == CLEAR);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_done) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB: begin
                cnt_d = '0;
                if (bus.clr_start) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Stage p0: select the write for this cycle; address and data hold when idle.
    always_comb begin
        c_reg_p0  = c_reg_p1;
        c_data_p0 = c_data_p1;
        vld_p0    = '0;
        case (state_q)
            CLEAR: begin
                c_reg_p0  = rep_reg(cnt_q[LOGREGS-1:0]);
                c_data_p0 = '0;
                vld_p0    = '1;
            end
            ARB: begin
                if (gnt[0]) begin
                    c_reg_p0  = rep_reg(bus.req0_reg);
                    c_data_p0 = bus.req0_data;
                    vld_p0    = bus.req0_mask;
                end else if (gnt[1]) begin
                    c_reg_p0  = rep_reg(bus.req1_reg);
                    c_data_p0 = bus.req1_data;
                    vld_p0    = bus.req1_mask;
                end
            end
            default: begin
                vld_p0 = '0;
            end
        endcase
    end

    // Stage p1: registered write port.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            c_reg_p1  <= '0;
            c_data_p1 <= '0;
            vld_p1    <= '0;
        end else begin
            c_reg_p1  <= c_reg_p0;
            c_data_p1 <= c_data_p0;
            vld_p1    <= vld_p0;
        end
    end

    assign bus.c_reg         = c_reg_p1;
    assign bus.c_writedatain = c_data_p1;
    assign bus.c_we          = vld_p1;

endmodule

// File: tb/tb_vflag_wr_sched.sv
// Directed bench for vflag_wr_sched: clear sequencing, round-robin grants,
// masks, clear pre-emption and asynchronous reset during a clear.
module tb_vflag_wr_sched;
    import vflag_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    int   errs;
    int   busy_hi;

    always #5 clk = ~clk;

    vflag_wr_sched_if bus ();

    vflag_wr_sched dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the cnt=0 clear cycle; returns at the first ARB cycle.
    task automatic run_clear(input bit pulse_mid, output int e, output int hi);
        e  = 0;
        hi = 0;
        for (int j = 1; j <= DEPTH; j++) begin
            logic [LOGREGS-1:0] r;
            tick();
            bus.clr_start = (pulse_mid && j == 100);
            r = LOGREGS'(j - 1);
            if (bus.c_we !== 2'b11 || bus.c_reg !== {r, r} || bus.c_writedatain !== 8'h00) e++;
            if (bus.clr_busy === 1'b1) hi++;
            if (j < DEPTH && bus.req0_ready !== 1'b0) e++;
            if (j == DEPTH && bus.clr_busy !== 1'b0) e++;
        end
        bus.clr_start = 1'b0;
    endtask

    initial begin
        resetn         = 1'b1;
        bus.clr_start  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_reg   = '0;
        bus.req0_data  = '0;
        bus.req0_mask  = '0;
        bus.req1_valid = 1'b1;
        bus.req1_reg   = '0;
        bus.req1_data  = '0;
        bus.req1_mask  = '0;

        repeat (3) tick();
        chk("rst_busy",  32'(bus.clr_busy), 32'd1);
        chk("rst_we",    32'(bus.c_we), 32'd0);
        chk("rst_reg",   32'(bus.c_reg), 32'd0);
        chk("rst_data",  32'(bus.c_writedatain), 32'd0);
        chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
        chk("rst_rdy1",  32'(bus.req1_ready), 32'd0);

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("clr0_busy_first", 32'(bus.clr_busy), 32'd1);
        run_clear(1'b0, errs, busy_hi);
        chk("clr0_seq_errs", 32'(errs), 32'd0);
        chk("clr0_busy_len", 32'(busy_hi + 1), 32'd512);

        bus.req0_valid = 1'b1;
        bus.req0_reg   = 9'd37;
        bus.req0_data  = 8'hA5;
        bus.req0_mask  = 2'b11;
        #1;
        chk("single_rdy0", 32'(bus.req0_ready), 32'd1);
        chk("single_rdy1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        chk("single_we",   32'(bus.c_we), 32'd3);
        chk("single_reg",  32'(bus.c_reg), 32'({9'd37, 9'd37}));
        chk("single_data", 32'(bus.c_writedatain), 32'hA5);

        bus.req1_valid = 1'b1;
        bus.req1_reg   = 9'd12;
        bus.req1_data  = 8'h3C;
        bus.req1_mask  = 2'b10;
        #1;
        chk("mask10_rdy1", 32'(bus.req1_ready), 32'd1);
        chk("mask10_rdy0", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.req1_reg  = 9'd13;
        bus.req1_data = 8'hFF;
        bus.req1_mask = 2'b00;
        chk("mask10_we",   32'(bus.c_we), 32'd2);
        chk("mask10_reg",  32'(bus.c_reg), 32'({9'd12, 9'd12}));
        chk("mask10_data", 32'(bus.c_writedatain), 32'h3C);
        #1;
        chk("mask00_rdy1", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        chk("mask00_we", 32'(bus.c_we), 32'd0);

        bus.req0_valid = 1'b1;
        bus.req0_reg   = 9'd5;
        bus.req0_data  = 8'h11;
        bus.req0_mask  = 2'b11;
        bus.req1_valid = 1'b1;
        bus.req1_reg   = 9'd6;
        bus.req1_data  = 8'h22;
        bus.req1_mask  = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_rdy0", k), 32'(bus.req0_ready), 32'((k % 2) == 0));
            chk($sformatf("rr%0d_rdy1", k), 32'(bus.req1_ready), 32'((k % 2) == 1));
            tick();
            if (k == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            if ((k % 2) == 0) begin
                chk($sformatf("rr%0d_we", k),   32'(bus.c_we), 32'd3);
                chk($sformatf("rr%0d_reg", k),  32'(bus.c_reg), 32'({9'd5, 9'd5}));
                chk($sformatf("rr%0d_data", k), 32'(bus.c_writedatain), 32'h11);
            end else begin
                chk($sformatf("rr%0d_we", k),   32'(bus.c_we), 32'd1);
                chk($sformatf("rr%0d_reg", k),  32'(bus.c_reg), 32'({9'd6, 9'd6}));
                chk($sformatf("rr%0d_data", k), 32'(bus.c_writedatain), 32'h22);
            end
        end
        tick();
        chk("rr_idle_we", 32'(bus.c_we), 32'd0);

        bus.req1_valid = 1'b1;
        bus.req1_reg   = 9'd7;
        bus.req1_data  = 8'h77;
        bus.req1_mask  = 2'b11;
        #1;
        chk("pre_clr_rdy1", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_reg   = 9'd9;
        bus.req0_data  = 8'h5A;
        bus.req0_mask  = 2'b01;
        bus.clr_start  = 1'b1;
        chk("pre_clr_we",   32'(bus.c_we), 32'd3);
        chk("pre_clr_reg",  32'(bus.c_reg), 32'({9'd7, 9'd7}));
        chk("pre_clr_data", 32'(bus.c_writedatain), 32'h77);
        #1;
        chk("clrstart_rdy0", 32'(bus.req0_ready), 32'd0);
        chk("clrstart_rdy1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.clr_start = 1'b0;
        chk("clr1_first_we",   32'(bus.c_we), 32'd0);
        chk("clr1_first_busy", 32'(bus.clr_busy), 32'd1);
        run_clear(1'b1, errs, busy_hi);
        chk("clr1_seq_errs", 32'(errs), 32'd0);
        chk("clr1_busy_len", 32'(busy_hi + 1), 32'd512);
        chk("post_clr_rdy0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        chk("post_clr_we",   32'(bus.c_we), 32'd1);
        chk("post_clr_reg",  32'(bus.c_reg), 32'({9'd9, 9'd9}));
        chk("post_clr_data", 32'(bus.c_writedatain), 32'h5A);

        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        repeat (200) tick();
        chk("mid_we",  32'(bus.c_we), 32'd3);
        chk("mid_reg", 32'(bus.c_reg), 32'({9'd199, 9'd199}));
        resetn = 1'b1;
        #1;
        chk("mid_rst_we",   32'(bus.c_we), 32'd0);
        chk("mid_rst_reg",  32'(bus.c_reg), 32'd0);
        chk("mid_rst_busy", 32'(bus.clr_busy), 32'd1);
        tick();
        resetn = 1'b0;
        #1;
        run_clear(1'b0, errs, busy_hi);
        chk("clr2_seq_errs", 32'(errs), 32'd0);
        chk("clr2_busy_len", 32'(busy_hi + 1), 32'd512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vflag_wr_sched.md
Name: vflag_wr_sched

Overview:
- Write-port controller for the per-lane vector flag register file: 2 lanes, 4-bit flags, 512 entries per lane, one write port c per lane.
- Sequences a bulk clear of every flag entry after reset and on command. The RAMs have no reset, so flags are undefined until cleared.
- Outside of a clear, round-robin arbitrates two flag-producing requesters (compare unit = req0, flag-logic unit = req1) onto write port c.
- Drives c_reg, c_writedatain and c_we of the flag register file directly, one cycle after acceptance.

Parameters:
- NUMLANES, 2, number of lanes (one write port per lane)
- WIDTH, 4, flag bits per lane entry
- LOGREGS, 9, address width; DEPTH = 2**LOGREGS = 512 entries

Ports:
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous, active-high reset (the port keeps the codebase name; it is active-high: 1 = reset)
- clr_start  in  1  one-cycle pulse requesting a full flag clear
- clr_busy  out  1  high while the clear sequence runs
- req0_valid  in  1  requester 0 has a write pending
- req0_ready  out  1  requester 0 accepted this cycle
- req0_reg  in  LOGREGS  target flag register (same address on all lanes)
- req0_data  in  NUMLANES*WIDTH  flag data; lane i in bits [i*WIDTH +: WIDTH]
- req0_mask  in  NUMLANES  per-lane write enable
- req1_valid, req1_ready, req1_reg, req1_data, req1_mask  same as req0, for requester 1
- c_reg  out  NUMLANES*LOGREGS  per-lane write address to the flag register file
- c_writedatain  out  NUMLANES*WIDTH  per-lane write data
- c_we  out  NUMLANES  per-lane write enable

Behaviour:
- Reset (async, resetn=1):
  - state=CLEAR, clear counter cnt=0, clr_busy=1, rr pointer favours req0.
  - c_we=0, c_reg=0, c_writedatain=0, both readies 0.
- Outputs c_* are registered. Write latency is 1 cycle: an accept in cycle N drives c_we in cycle N+1.
- c_we is high for exactly one cycle per accepted write; otherwise c_we=0.
- CLEAR state:
  - Each cycle register c_reg = cnt replicated on all lanes, c_writedatain=0, c_we=all ones. Then cnt++.
  - The write with cnt=DEPTH-1 is the last. The next cycle enters ARB with cnt=0 and clr_busy=0.
  - A clear is exactly DEPTH write cycles; clr_busy is high for exactly those DEPTH cycles.
  - Both readies are 0 throughout CLEAR. clr_start is ignored during CLEAR (no restart).
- ARB state:
  - readies are combinational from valids, the rr pointer and clr_start.
  - Only one valid: that requester is granted.
  - Both valid: the requester favoured by the pointer is granted. After a grant the pointer favours the other requester.
  - If neither is valid, the pointer does not change.
  - At most one ready is high per cycle. An accept is valid && ready.
  - On accept, next cycle:
    - c_reg = winner reg replicated on all lanes
    - c_writedatain = winner data
    - c_we = winner mask
  - A mask of 0 still completes the handshake, and c_we=0 results.
- clr_start in ARB:
  - Takes priority; no grant in that cycle, both readies 0.
  - Enters CLEAR next cycle with cnt=0.
  - A write accepted in the previous cycle still issues normally on c_*.
- Requester protocol: valid, reg, data and mask are held stable until accepted. The scheduler does not check this.
- Reset asserted mid-clear or mid-write: immediate return to reset values. The clear restarts from 0 after resetn falls.
- Arithmetic: cnt is LOGREGS+1 bits. Completion is detected at cnt==DEPTH-1, with no wrap aliasing.

Decomposition:
- Package vflag_pkg holds:
  - constants NUMLANES, WIDTH, LOGREGS, DEPTH
  - state encoding CLEAR=0, ARB=1
  - lane-slice helper widths
- One sub-module, rr_arb2: a two-requester round-robin arbiter.
  - Inputs: req[1:0], en.
  - Outputs: gnt[1:0], one-hot or 0.
  - Internal pointer, updated only on a grant.

Test Plan:
- Release reset -> clr_busy=1 for exactly 512 cycles. c_we=2'b11 with data 0 and c_reg stepping 0..511 on both lanes. Then clr_busy=0, and readies respond from the next cycle.
- After clear, req0 valid alone (reg=9'd37, data=8'hA5, mask=2'b11) -> req0_ready=1 the same cycle. Next cycle: c_reg={9'd37,9'd37}, c_writedatain=8'hA5, c_we=2'b11 for one cycle.
- req0 and req1 both held valid for 4 cycles -> grants 0,1,0,1. Each is followed one cycle later by the matching c_* write, and c_we is never active for both requesters in one cycle.
- req1 with mask=2'b10, data=8'h3C -> c_we=2'b10 and c_writedatain=8'h3C. Then mask=2'b00 -> ready=1 and c_we stays 0.
- clr_start pulsed while req0 valid -> no ready that cycle; CLEAR runs 512 cycles with req0_ready=0 throughout. req0 is granted in the first ARB cycle, and a clr_start during CLEAR does not extend it.
- Assert resetn at clear step 200 -> c_we=0 at once. After release the clear restarts at c_reg=0 and runs a full 512 cycles.
